oam_dma: RTL

OAM DMA engine: the writer side of the OAM port. A CPU write to register FF46 copies 160 bytes from `{page, 8'h00}` into OAM at one byte per M-cycle. It drives the `dma_active`, `oam_wr`, `oam_addr_in` and `oam_di` inputs of the sprite/OAM block, and issues reads on the system bus through the memory arbiter. While `dma_active` is high, the arbiter blocks CPU access to everything except HRAM.

---
 rtl/oam_dma_if.sv | 51 +++++
 rtl/oam_dma.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_if.sv
// ---------------------------------------------------------------------------
// oam_dma_if
//
// Bundles the signals of the OAM DMA engine. These are the CPU register port
// for FF46, the system-bus read port through the memory arbiter, and the
// writer side of the OAM port.
//
// Handshake semantics: there is no valid/ready pair here. Every transfer is
// qualified by the shared T-cycle enable ce_cpu, which is not part of this
// bundle.
//   - A CPU register write takes effect only on a strobe where
//     ce_cpu & cpu_sel & cpu_wr are all high.
//   - A bus read is requested whenever dma_rd is high.
//     dma_rd_data must be valid by the phase-3 strobe of the M-cycle,
//     and it is consumed only on that strobe.
//   - An OAM byte is written on a strobe where ce_cpu & oam_wr are both high.
//
// Modports:
//   master - the DMA engine (drives reg_do, dma_*, oam_*)
//   slave  - the surrounding system (CPU decode, arbiter/memory, OAM block)
// ---------------------------------------------------------------------------
interface oam_dma_if;
    // CPU register port
    logic        cpu_sel;      // CPU addresses FF46
    logic        cpu_wr;       // CPU write strobe
    logic [7:0]  cpu_di;       // CPU write data (source page)
    logic [7:0]  reg_do;       // FF46 readback

    // System bus read port
    logic        dma_active;   // transfer in progress; arbiter blocks CPU
    logic        dma_rd;       // bus read request
    logic [15:0] dma_rd_addr;  // bus read address
    logic [7:0]  dma_rd_data;  // bus read data

    // OAM write port
    logic        oam_wr;       // OAM write, qualified by ce_cpu downstream
    logic [7:0]  oam_addr;     // OAM byte address
    logic [7:0]  oam_di;       // OAM write data

    modport master (
        input  cpu_sel, cpu_wr, cpu_di, dma_rd_data,
        output reg_do, dma_active, dma_rd, dma_rd_addr,
               oam_wr, oam_addr, oam_di
    );

    modport slave (
        output cpu_sel, cpu_wr, cpu_di, dma_rd_data,
        input  reg_do, dma_active, dma_rd, dma_rd_addr,
               oam_wr, oam_addr, oam_di
    );
endinterface

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
//
// OAM DMA engine. A CPU write to FF46 copies DMA_LEN bytes from page
// {page, 8'h00} into OAM at one byte per M-cycle. An M-cycle is four ce_cpu
// strobes.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   ce_cpu     T-cycle clock enable; all state holds while it is low
//   bus        oam_dma_if.master (CPU FF46 port, bus read port, OAM write port)
//   state_dbg  current FSM state (0 = IDLE, 1 = SETUP, 2 = XFER)
//
// Flow: IDLE -> SETUP (four strobes) -> XFER (DMA_LEN M-cycles) -> IDLE.
//
// A write to FF46 during XFER schedules a restart four strobes later. The
// restart takes effect on the next phase-3 strobe once the countdown has
// expired. If the old transfer ends before that point, the engine drops
// back into SETUP with the remaining countdown.
// ---------------------------------------------------------------------------
module oam_dma #(
    parameter int DMA_LEN = 160
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_cpu,
    oam_dma_if.master  bus,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
    localparam logic [2:0] DELAY_LOAD = 3'd4;

    // Registered state
    state_t     state_q;
    logic [7:0] reg_q;
    logic [7:0] src_q;
    logic [7:0] idx_q;
    logic [1:0] phase_q;
    logic [2:0] setup_q;
    logic [2:0] rcnt_q;
    logic       rpend_q;

    // Next-state values
    state_t     state_d;
    logic [7:0] reg_d;
    logic [7:0] src_d;
    logic [7:0] idx_d;
    logic [1:0] phase_d;
    logic [2:0] setup_d;
    logic [2:0] rcnt_d;
    logic       rpend_d;

    // Helpers
    logic       wr_acc;
    logic [2:0] setup_dec;
    logic [2:0] rcnt_dec;
    logic       restart_due;
    logic [7:0] src_eff;

    assign wr_acc = ce_cpu & bus.cpu_sel & bus.cpu_wr;

    // Both countdowns saturate at zero so that a stale value cannot wrap.
    assign setup_dec = (setup_q != 3'd0) ? setup_q - 3'd1 : 3'd0;
    assign rcnt_dec  = (rcnt_q  != 3'd0) ? rcnt_q  - 3'd1 : 3'd0;

    // This strobe's decrement counts toward the restart deadline.
    assign restart_due = rpend_q & (rcnt_dec == 3'd0);

    // Echo RAM pages (E0..FF) alias onto WRAM (C0..DF). Because src_q is at
    // least E0 when 20 is subtracted, the 8-bit subtraction cannot borrow.
    assign src_eff = (src_q >= 8'hE0) ? src_q - 8'h20 : src_q;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            reg_q   <= 8'h00;
            src_q   <= 8'h00;
            idx_q   <= 8'h00;
            phase_q <= 2'd0;
            setup_q <= 3'd0;
            rcnt_q  <= 3'd0;
            rpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            setup_q <= setup_d;
            rcnt_q  <= rcnt_d;
            rpend_q <= rpend_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        src_d   = src_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        setup_d = setup_q;
        rcnt_d  = rcnt_q;
        rpend_d = rpend_q;

        if (ce_cpu) begin
            // Autonomous progress of the current state
            case (state_q)
                S_IDLE: begin
                end

                S_SETUP: begin
                    setup_d = setup_dec;
                    if (setup_dec == 3'd0) begin
                        state_d = S_XFER;
                        src_d   = reg_q;
                        idx_d   = 8'h00;
                        phase_d = 2'd0;
                    end
                end

                S_XFER: begin
                    phase_d = phase_q + 2'd1;
                    rcnt_d  = rcnt_dec;
                    if (phase_q == 2'd3) begin
                        // This strobe writes the byte at the current idx/src.
                        // The bookkeeping below affects only the next M-cycle.
                        if (restart_due) begin
                            idx_d   = 8'h00;
                            src_d   = reg_q;
                            rpend_d = 1'b0;
                        end else if (idx_q == LAST_IDX) begin
                            if (rpend_q) begin
                                // Old copy ended before the restart deadline.
                                // Wait out the remainder in SETUP.
                                state_d = S_SETUP;
                                setup_d = rcnt_dec;
                                phase_d = 2'd0;
                                rpend_d = 1'b0;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            idx_d = idx_q + 8'h01;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // A register write lands on top of whatever state results from
            // the progress above.
            if (wr_acc) begin
                reg_d = bus.cpu_di;
                case (state_d)
                    S_IDLE: begin
                        state_d = S_SETUP;
                        setup_d = DELAY_LOAD;
                        phase_d = 2'd0;
                    end
                    S_SETUP: begin
                        setup_d = DELAY_LOAD;
                    end
                    S_XFER: begin
                        rpend_d = 1'b1;
                        rcnt_d  = DELAY_LOAD;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        bus.reg_do      = reg_q;
        bus.dma_active  = (state_q == S_XFER);
        bus.dma_rd      = (state_q == S_XFER);
        bus.dma_rd_addr = {src_eff, idx_q};
        bus.oam_wr      = (state_q == S_XFER) && (phase_q == 2'd3);
        bus.oam_addr    = idx_q;
        bus.oam_di      = bus.dma_rd_data;
        state_dbg       = state_q;
    end

endmodule
